// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port, with bounded retry on overflow
module fifo_wr_arbiter #(
  parameter int FIFO_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int MAX_RETRY  = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic                          drop_err,
  input  logic                          full,
  input  logic                          wr_ack,
  input  logic                          overflow,
  output logic                          wr_en,
  output logic [FIFO_WIDTH-1:0]         data_in,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [1:0] IDLE = 2'd0, WRITE = 2'd1, RESP = 2'd2, BACKOFF = 2'd3;
  logic [1:0]            state;
  logic [IW-1:0]         rr_ptr, winner, idx, next_ptr;
  logic [3:0]            retry_cnt;
  logic [NUM_REQ-1:0]    eligible, gnt_oh;
  logic [FIFO_WIDTH-1:0] win_data;
  logic                  found;
  logic                  unused_overflow;
  // a requester acked this cycle still shows req_valid; mask it so it is not regranted
  assign eligible = req_valid & ~req_ack;
  assign next_ptr = grant_id == IW'(NUM_REQ - 1) ? '0 : grant_id + 1'b1;
  assign gnt_oh   = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
  assign busy     = state != IDLE;
  // any response without wr_ack is a failed write, so overflow adds no information
  assign unused_overflow = overflow;
  always_comb begin
    winner   = rr_ptr;
    found    = 1'b0;
    idx      = '0;
    win_data = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx    = IW'((int'(rr_ptr) + i) % NUM_REQ);
      winner = eligible[idx] ? idx : winner;
      found  = found | eligible[idx];
    end
    for (int i = 0; i < NUM_REQ; i++)
      win_data = IW'(i) == winner ? req_data[i*FIFO_WIDTH +: FIFO_WIDTH] : win_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_en     <= 1'b0;
      data_in   <= '0;
      req_ack   <= '0;
      drop_err  <= 1'b0;
      grant_id  <= '0;
      rr_ptr    <= '0;
      retry_cnt <= '0;
    end else begin
      wr_en    <= 1'b0;
      req_ack  <= '0;
      drop_err <= 1'b0;
      case (state)
        IDLE: if (found && !full) begin
          data_in   <= win_data;
          grant_id  <= winner;
          wr_en     <= 1'b1;
          retry_cnt <= '0;
          state     <= WRITE;
        end
        WRITE: state <= RESP;
        RESP: if (wr_ack || retry_cnt == 4'(MAX_RETRY)) begin
          req_ack  <= gnt_oh;
          drop_err <= !wr_ack;
          rr_ptr   <= next_ptr;
          state    <= IDLE;
        end else begin
          retry_cnt <= retry_cnt + 1'b1;
          state     <= BACKOFF;
        end
        default: if (!full) begin
          wr_en <= 1'b1;
          state <= WRITE;
        end
      endcase
    end
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the team's synchronous FIFO (FIFO_WIDTH=16, FIFO_DEPTH=8) between NUM_REQ requesters.
- Latches the winning word, drives wr_en/data_in for exactly one cycle, then checks wr_ack/overflow.
- On success, acknowledges the requester. On overflow, it backs off until the FIFO is not full and retries, up to MAX_RETRY times.
- Sits between producer blocks and the FIFO DUT modport. The read side is untouched.

Parameters:
- FIFO_WIDTH, 16, data word width.
- NUM_REQ, 4, number of requesters (2..8).
- MAX_RETRY, 3, retries after the first failed write before the word is dropped (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester write request; must be held with data stable until req_ack.
- req_data  input  NUM_REQ*FIFO_WIDTH  packed words; requester i uses bits [i*FIFO_WIDTH +: FIFO_WIDTH].
- req_ack  output  NUM_REQ  one-hot, one-cycle pulse: request i completed (written or dropped).
- drop_err  output  1  one-cycle pulse coincident with req_ack when the word was dropped.
- full  input  1  FIFO full flag.
- wr_ack  input  1  FIFO write acknowledge (registered in FIFO, valid the cycle after wr_en).
- overflow  input  1  FIFO overflow flag (same timing as wr_ack).
- wr_en  output  1  FIFO write enable, registered.
- data_in  output  FIFO_WIDTH  FIFO write data, registered.
- grant_id  output  $clog2(NUM_REQ)  index of the current/last winner, registered.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; wr_en=0, data_in=0, req_ack=0, drop_err=0, grant_id=0, busy=0.
  - rr_ptr=0, retry_cnt=0.
  - Any in-flight word is lost with no ack. Release is synchronous to clk.
- States: IDLE, WRITE, RESP, BACKOFF.
- IDLE:
  - eligible = req_valid & ~req_ack (requester acked this cycle is masked).
  - If eligible!=0 and full==0: winner = first set bit searching upward from rr_ptr with wrap-around.
  - Register data_in=req_data[winner], grant_id=winner, wr_en=1, retry_cnt=0; go to WRITE.
  - If full==1 or no eligible request: stay IDLE, wr_en=0.
- WRITE: wr_en is high for exactly this one cycle; the next state clears it. Go to RESP.
- RESP (sample wr_ack/overflow):
  - wr_ack=1: next cycle req_ack[grant_id]=1, drop_err=0; rr_ptr=(grant_id+1) mod NUM_REQ; go to IDLE.
  - Otherwise (overflow=1, or neither flag asserted), with retry_cnt<MAX_RETRY: retry_cnt++, go to BACKOFF.
  - Otherwise, with retry_cnt==MAX_RETRY: next cycle req_ack[grant_id]=1 and drop_err=1; rr_ptr advances; go to IDLE.
- BACKOFF:
  - Hold data_in and grant_id, wr_en=0.
  - When full==0, set wr_en=1 and go to WRITE. No cycle limit on waiting.
- Latency, uncontended, FIFO not full: request seen in IDLE at cycle T; wr_en=1 in T+1; wr_ack sampled in T+2; req_ack pulse in T+3.
- Throughput: one word per 3 cycles (the req_ack cycle overlaps the next IDLE).
- Fairness: after a completed request, that requester has lowest priority. No requester waits more than NUM_REQ-1 grants.
- data_in changes only on the IDLE->WRITE transition. It is never modified during WRITE/RESP/BACKOFF.
- Requester dropping req_valid before req_ack is illegal. The arbiter still completes the latched word and pulses req_ack.
- req_ack is always one-hot or zero, and is never asserted while wr_en=1.

Test Plan:
- Single requester 0, word 16'hA5A5, FIFO empty -> wr_en high at T+1 with data_in=16'hA5A5; req_ack=4'b0001 at T+3; drop_err=0.
- All 4 requesters valid continuously, rr_ptr=0 -> grant order 0,1,2,3,0; each req_ack one-hot; 5 writes in 15 cycles.
- FIFO pre-filled with 8 words, req 2 valid -> arbiter stays IDLE with wr_en=0. Read one word (full=0) -> write issued; req_ack=4'b0100.
- Force overflow=1, wr_ack=0 on every attempt, MAX_RETRY=3 -> 4 wr_en pulses total, then req_ack and drop_err pulse together; data_in constant across all attempts.
- Assert rst_n=0 during BACKOFF -> all outputs 0 immediately (async). After release, same request is regranted from rr_ptr=0 and completes normally.
- Requester 1 acked and keeps req_valid=1 in the ack cycle, requester 3 valid -> requester 3 is granted next, not 1.
